// File: rtl/coe_acc_pkg.sv
// Shared types and helpers for the coefficient accumulator (coe_accum_iq).
// Holds the mode encodings and the saturate/wrap width-fitting functions.
package coe_acc_pkg;

  typedef enum logic {
    ACC   = 1'b0,
    LEAKY = 1'b1
  } mode_e;

  localparam int unsigned CALC_W = 64;

  // Fit a wide signed value into w bits: clamp when sat is set, else two's complement wrap.
  function automatic logic signed [CALC_W-1:0] fit_w(
    input logic signed [CALC_W-1:0] v,
    input int unsigned              w,
    input logic                     sat
  );
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    logic signed [CALC_W-1:0] m;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    m  = v & ((64'sd1 <<< w) - 64'sd1);
    if (m > hi) m = m - (64'sd1 <<< w);
    if (sat) begin
      if (v > hi)      fit_w = hi;
      else if (v < lo) fit_w = lo;
      else             fit_w = v;
    end else begin
      fit_w = m;
    end
  endfunction

  // True when v lies outside the signed range of w bits.
  function automatic logic fit_ovf(
    input logic signed [CALC_W-1:0] v,
    input int unsigned              w
  );
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    fit_ovf = (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/coe_dline.sv
// Register-based circular delay line: DEPTH x W entries, one read and one write at ptr.
// Synchronous active-low clear of all entries.
module coe_dline #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_ptr,
  input  logic signed [W-1:0]        i_wdata,
  output logic signed [W-1:0]        o_rdata_c
);

  logic signed [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_ptr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_ptr];

endmodule

// File: rtl/coe_accum_iq.sv
// I/Q coefficient accumulator over a DEPTH-slot circular delay line (accumulate or leaky mode).
// Define COE_ACC_SAT_EN to saturate results and enable the sticky ovf flag; otherwise results wrap.
module coe_accum_iq
  import coe_acc_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned LAMDA = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [W-1:0]        x_i,
  input  logic signed [W-1:0]        x_q,
  input  logic                       mode,
  input  logic                       clr,
  output logic signed [W-1:0]        y_i,
  output logic signed [W-1:0]        y_q,
  output logic                       out_valid,
  output logic                       out_sof,
  output logic [$clog2(DEPTH)-1:0]   out_slot,
  output logic                       ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WE = W + 2;

  logic [AW-1:0]        r_ptr;
  logic [CW-1:0]        r_clr_cnt;
  logic                 w_clearing;
  logic signed [W-1:0]  w_x   [2];
  logic signed [W-1:0]  w_rd  [2];
  logic signed [W-1:0]  w_old [2];
  logic signed [WE-1:0] w_sum [2];
  logic signed [W-1:0]  w_new [2];
`ifdef COE_ACC_SAT_EN
  logic                 w_sat [2];
`endif

  assign w_x[0]     = x_i;
  assign w_x[1]     = x_q;
  assign w_clearing = clr || (r_clr_cnt != '0);

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    coe_dline #(.W(W), .DEPTH(DEPTH)) u_dline (
      .clk       (clk),
      .reset     (reset),
      .i_we      (in_valid),
      .i_ptr     (r_ptr),
      .i_wdata   (w_new[ch]),
      .o_rdata_c (w_rd[ch])
    );

    // Clearing passes read zero instead of the stored slot value.
    assign w_old[ch] = w_clearing ? '0 : w_rd[ch];
    assign w_sum[ch] = (mode_e'(mode) == LEAKY)
                     ? WE'(w_old[ch]) - WE'(w_old[ch] >>> LAMDA) + WE'(w_x[ch] >>> LAMDA)
                     : WE'(w_old[ch]) + WE'(w_x[ch] >>> LAMDA);

`ifdef COE_ACC_SAT_EN
    assign w_new[ch] = W'(fit_w(CALC_W'(w_sum[ch]), W, 1'b1));
    assign w_sat[ch] = fit_ovf(CALC_W'(w_sum[ch]), W);
`else
    assign w_new[ch] = W'(fit_w(CALC_W'(w_sum[ch]), W, 1'b0));
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr     <= '0;
      r_clr_cnt <= '0;
      y_i       <= '0;
      y_q       <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_slot  <= '0;
    end else begin
      out_valid <= in_valid;
      out_sof   <= in_valid && (r_ptr == '0);
      // A clr with a sample counts that sample as the first cleared one.
      if (clr)
        r_clr_cnt <= in_valid ? CW'(DEPTH - 1) : CW'(DEPTH);
      else if (in_valid && (r_clr_cnt != '0))
        r_clr_cnt <= r_clr_cnt - 1'b1;
      if (in_valid) begin
        r_ptr    <= r_ptr + 1'b1;
        out_slot <= r_ptr;
        y_i      <= w_new[0];
        y_q      <= w_new[1];
      end
    end
  end

`ifdef COE_ACC_SAT_EN
  always_ff @(posedge clk) begin
    if (!reset)
      ovf <= 1'b0;
    else if (in_valid && (w_sat[0] || w_sat[1]))
      ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/coe_accum_iq.md
COE_ACCUM_IQ -- requirements
Module: coe_accum_iq

Interface
REQ-001 Parameter W, default 16, signed I/Q sample and output width.
REQ-002 Parameter DEPTH, default 32, delay-line length in samples (slots); power of two, min 4.
REQ-003 Parameter LAMDA, default 8, arithmetic right-shift applied to input (and to feedback in leaky mode); range 0..W-1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  sample strobe; delay line advances only when high.
REQ-007 x_i, x_q  input  W each  signed input sample.
REQ-008 mode  input  1  0 = accumulate, 1 = leaky integrate; sampled with in_valid.
REQ-009 clr  input  1  one-cycle pulse; arms a full-pass clear.
REQ-010 y_i, y_q  output  W each  signed updated coefficient for current slot.
REQ-011 out_valid  output  1  high one cycle after each accepted in_valid.
REQ-012 out_sof  output  1  high with out_valid when output belongs to slot 0.
REQ-013 out_slot  output  log2(DEPTH)  slot index of current output.
REQ-014 ovf  output  1  sticky overflow flag.

Function
REQ-015 Each channel (I, Q) SHALL hold DEPTH signed W-bit entries addressed by a shared write pointer ptr.
REQ-016 On in_valid, old = mem[ptr] (or 0 if clearing); xs = x >>> LAMDA (arithmetic).
REQ-017 mode 0: new = old + xs; mode 1: new = old - (old >>> LAMDA) + xs; computed at W+2 bits signed.
REQ-018 new SHALL be written to mem[ptr] and registered to y in the same edge; latency in_valid -> out_valid = 1 cycle.
REQ-019 ptr increments per accepted sample, wraps DEPTH-1 -> 0; out_slot = ptr value used; out_sof = (out_slot == 0).
REQ-020 in_valid low: ptr, mem, y, out_slot held; out_valid and out_sof low.
REQ-021 clr loads a clear counter with DEPTH; while nonzero each accepted sample uses old = 0 and decrements it; clr during an active clear reloads DEPTH; clr coincident with in_valid applies to that sample.
REQ-022 I and Q paths SHALL be identical and independent except for shared ptr, clear counter, ovf.

Reset
REQ-023 reset low at a clock edge: all mem entries 0, ptr 0, clear counter 0, y_i/y_q 0, out_valid 0, out_sof 0, out_slot 0, ovf 0.
REQ-024 reset mid-operation SHALL discard any sample presented that cycle; reset dominates in_valid and clr.

Configuration
REQ-025 Macro COE_ACC_SAT_EN defined: new SHALL saturate to [-2^(W-1), 2^(W-1)-1] on both write and output; any saturation sets ovf until reset.
REQ-026 COE_ACC_SAT_EN undefined: new SHALL wrap modulo 2^W (two's complement truncation); ovf tied 0.

Structure
REQ-027 Package coe_acc_pkg SHALL hold mode encodings (ACC, LEAKY) and the saturate/wrap width function.
REQ-028 One sub-module coe_dline: DEPTH x W register-based circular buffer with sync clear, one read and one write at ptr; instantiated once per channel.

Verification (W=16, DEPTH=32)
REQ-029 Reset: drive reset low 2 cycles with in_valid high -> y=0, out_valid=0, out_slot=0, ovf=0.
REQ-030 Accumulate, LAMDA=8: x_i=256, x_q=-512 for 96 samples -> slot k outputs (1,-2), (2,-4), (3,-6) on passes 1..3; out_sof on samples 0, 32, 64.
REQ-031 Leaky, LAMDA=8: x_i=16384 -> pass 1 y_i=64, pass 2 y_i=128.
REQ-032 Overflow, LAMDA=0, mode 0: x_i=20000 two passes -> with macro y_i=32767, ovf=1; without macro y_i=-25536, ovf=0.
REQ-033 Clear: after 3 accumulate passes at x_i=256, pulse clr -> next 32 outputs y_i=1, following pass y_i=2.
REQ-034 Gaps: in_valid pattern 1,0,0,1 -> out_valid 0,1,0,0,1 delayed one cycle, out_slot 0 then 1, y held during gaps.
